// File: rtl/adder_share_pkg.sv
// adder_share_pkg
// Shared definitions for the adder-sharing controller: controller state
// encoding, default parameter values and the ID-width helper.
// No ports (package).
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_N      = 8;
    localparam int DEF_R      = 4;
    localparam int DEF_SETTLE = 1;

    // Width needed to index 'value' items; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// adder_share_ctrl_if
// Requester/consumer-side bus of the adder-sharing controller.
//   req, req_a, req_b, req_cin : requests with packed operands (requester i at [i*N +: N])
//   gnt                         : one-hot pulse, operands of that requester captured
//   resp_valid/resp_ready       : result handshake
//   resp_id, resp_sum, resp_cout: result payload
//   resp_ovf                    : signed overflow, present only with ADDER_SHARE_OVF_EN
// Modports: master = requesters plus result consumer, slave = controller.
interface adder_share_ctrl_if import adder_share_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int R = DEF_R
);
    localparam int IDW = clog2(R);

    logic [R-1:0]   req;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_cin;
    logic [R-1:0]   gnt;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [N-1:0]   resp_sum;
    logic           resp_cout;
`ifdef ADDER_SHARE_OVF_EN
    logic           resp_ovf;

    modport master (
        output req, req_a, req_b, req_cin, resp_ready,
        input  gnt, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );
    modport slave (
        input  req, req_a, req_b, req_cin, resp_ready,
        output gnt, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );
`else
    modport master (
        output req, req_a, req_b, req_cin, resp_ready,
        input  gnt, resp_valid, resp_id, resp_sum, resp_cout
    );
    modport slave (
        input  req, req_a, req_b, req_cin, resp_ready,
        output gnt, resp_valid, resp_id, resp_sum, resp_cout
    );
`endif

endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: first set bit of req searched from ptr
// upward with wrap-around.
//   req     in  R    request levels
//   ptr     in  IDW  highest-priority index
//   win_oh  out R    one-hot winner (zero when no request)
//   win_idx out IDW  winner index
//   win_any out 1    at least one request present
module rr_arbiter import adder_share_pkg::*;
#(
    parameter int R   = DEF_R,
    parameter int IDW = clog2(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   win_oh,
    output logic [IDW-1:0] win_idx,
    output logic           win_any
);

    int scan_idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        win_oh   = '0;
        win_idx  = '0;
        win_any  = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < R; i++) begin
            scan_idx = (int'(ptr) + i) % R;
            if (!win_any && req[scan_idx]) begin
                win_any          = 1'b1;
                win_oh[scan_idx] = 1'b1;
                win_idx          = IDW'(scan_idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
// Time-shares one external N-bit adder among R requesters. A round-robin
// winner's operands are registered onto the adder, held SETTLE cycles, then
// sum/carry are captured and returned with a valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : requests, grants and tagged results
//   add_a/add_b/add_cin : registered operands to the adder
//   add_sum/add_cout    : adder outputs (combinational from add_*)
// Optional: ADDER_SHARE_OVF_EN adds bus.resp_ovf (signed overflow of the result).
// The bus interface must be instantiated with the same N and R.
module adder_share_ctrl import adder_share_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int R      = DEF_R,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_ctrl_if.slave    bus,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_sum,
    input  logic                 add_cout
);

    localparam int IDW = clog2(R);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [R-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   add_a_q, add_a_d;
    logic [N-1:0]   add_b_q, add_b_d;
    logic           add_cin_q, add_cin_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [N-1:0]   resp_sum_q, resp_sum_d;
    logic           resp_cout_q, resp_cout_d;
    logic           resp_ovf_q, resp_ovf_d;

    logic [R-1:0]   win_oh;
    logic [IDW-1:0] win_idx;
    logic           win_any;

    rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;    // grant is a single-cycle pulse
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_cin_d    = add_cin_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_cout_d  = resp_cout_q;
        resp_ovf_d   = resp_ovf_q;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_d     = win_oh;
                    add_a_d   = bus.req_a[win_idx*N +: N];
                    add_b_d   = bus.req_b[win_idx*N +: N];
                    add_cin_d = bus.req_cin[win_idx];
                    id_d      = win_idx;
                    cnt_d     = 4'(SETTLE - 1);
                    ptr_d     = (win_idx == IDW'(R - 1)) ? '0 : win_idx + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    resp_sum_d   = add_sum;
                    resp_cout_d  = add_cout;
                    // Signed overflow: like-signed operands, sum sign differs.
                    resp_ovf_d   = (add_a_q[N-1] == add_b_q[N-1]) &&
                                   (add_sum[N-1] != add_a_q[N-1]);
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_cin_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_cin_q    <= add_cin_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_ovf_q   <= resp_ovf_d;
        end
    end

    assign add_a          = add_a_q;
    assign add_b          = add_b_q;
    assign add_cin        = add_cin_q;
    assign bus.gnt        = gnt_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_cout  = resp_cout_q;
`ifdef ADDER_SHARE_OVF_EN
    assign bus.resp_ovf   = resp_ovf_q;
`else
    // Overflow flag is not exported in this build; keep the flop observable
    // to nothing so synthesis removes it.
    logic unused_ovf;
    assign unused_ovf = resp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl
// Self-checking bench: a scoreboard queue gets the expected result on every
// observed grant and is popped on every accepted response. A second instance
// with SETTLE=4 covers the longer settle window.
module tb_adder_share_ctrl;
    import adder_share_pkg::*;

    localparam int N   = 8;
    localparam int R   = 4;
    localparam int IDW = clog2(R);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   sum;
        logic           cout;
        logic           ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adder_share_ctrl_if #(.N(N), .R(R)) bus ();
    adder_share_ctrl_if #(.N(N), .R(R)) bus4 ();

    logic [N-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic [N-1:0] add_a4, add_b4, add_sum4;
    logic         add_cin4, add_cout4;

    // Behavioural stand-ins for the external ripple adders.
    assign {add_cout, add_sum}   = (N+1)'(add_a)  + (N+1)'(add_b)  + (N+1)'(add_cin);
    assign {add_cout4, add_sum4} = (N+1)'(add_a4) + (N+1)'(add_b4) + (N+1)'(add_cin4);

    adder_share_ctrl #(.N(N), .R(R), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    adder_share_ctrl #(.N(N), .R(R), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input int id, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic cin);
        exp_t e;
        logic [N:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        e.id   = IDW'(id);
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        return e;
    endfunction

    logic [N-1:0] a_v [R];
    logic [N-1:0] b_v [R];
    logic         cin_v [R];

    exp_t sb_q [$];
    int   glog_id [$];
    int   glog_cyc [$];
    int   mon_gid;
    exp_t mon_e;

    // Grant/response monitor for the main instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != '0) begin
                check("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
                mon_gid = 0;
                for (int i = 0; i < R; i++) if (bus.gnt[i]) mon_gid = i;
                sb_q.push_back(model(mon_gid, a_v[mon_gid], b_v[mon_gid], cin_v[mon_gid]));
                glog_id.push_back(mon_gid);
                glog_cyc.push_back(cyc);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_id",   32'(bus.resp_id),   32'(mon_e.id));
                    check("resp_sum",  32'(bus.resp_sum),  32'(mon_e.sum));
                    check("resp_cout", 32'(bus.resp_cout), 32'(mon_e.cout));
`ifdef ADDER_SHARE_OVF_EN
                    check("resp_ovf",  32'(bus.resp_ovf),  32'(mon_e.ovf));
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin);
        a_v[id]   = a;
        b_v[id]   = b;
        cin_v[id] = cin;
        bus.req_a[id*N +: N] = a;
        bus.req_b[id*N +: N] = b;
        bus.req_cin[id]      = cin;
    endtask

    task automatic wait_gnt(output int got);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_dut();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        sb_q.delete();
        step();
        rst_n = 1'b1;
    endtask

    // Single request from 'id'; checks grant, SETTLE=1 latency and completion.
    task automatic do_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin);
        int got;
        int lat;
        step();
        set_op(id, a, b, cin);
        bus.req[id] = 1'b1;
        wait_gnt(got);
        check("op_gnt_seen", 32'(got), 32'd1);
        check("op_gnt", 32'(bus.gnt), 32'(1 << id));
        bus.req[id] = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
        end
        check("op_latency", 32'(lat), 32'd1);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.resp_valid) begin
                got = 1;
                break;
            end
        end
        check("op_resp_done", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        int   n;
        exp_t e;

        rst_n           = 1'b0;
        bus.req         = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_cin     = '0;
        bus.resp_ready  = 1'b1;
        bus4.req        = '0;
        bus4.req_a      = '0;
        bus4.req_b      = '0;
        bus4.req_cin    = '0;
        bus4.resp_ready = 1'b1;
        for (int i = 0; i < R; i++) begin
            a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
        end

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_gnt",        32'(bus.gnt),        32'd0);
        check("rst_add_a",      32'(add_a),          32'd0);
        check("rst_add_b",      32'(add_b),          32'd0);
        check("rst_add_cin",    32'(add_cin),        32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_id",    32'(bus.resp_id),    32'd0);
        check("rst_resp_sum",   32'(bus.resp_sum),   32'd0);
        check("rst_resp_cout",  32'(bus.resp_cout),  32'd0);
        step();
        rst_n = 1'b1;

        // Single requests: plain add, carry-out, signed overflow, wrap to zero.
        do_op(0, 8'h0F, 8'h01, 1'b0);
        do_op(2, 8'hFF, 8'h01, 1'b1);
        do_op(3, 8'h7F, 8'h01, 1'b0);
        do_op(1, 8'h80, 8'h80, 1'b0);
        drain();

        // Round-robin with all four requesting continuously.
        reset_dut();
        for (int i = 0; i < R; i++) set_op(i, 8'(8'h10 * i + 3), 8'(8'hF0 + i), i[0]);
        glog_id.delete();
        glog_cyc.delete();
        bus.req = 4'b1111;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (glog_id.size() >= 5) break;
        end
        bus.req = '0;
        check("rr_grant_count", 32'(glog_id.size()), 32'd5);
        for (int i = 0; i < glog_id.size() && i < 5; i++) begin
            check("rr_order", 32'(glog_id[i]), 32'(i % R));
            if (i > 0) check("rr_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd3);
        end
        drain();

        // Backpressure: pointer now at 1, requesters 1 and 2 ask, consumer stalls.
        step();
        bus.resp_ready = 1'b0;
        set_op(1, 8'hA5, 8'h3C, 1'b1);
        set_op(2, 8'h11, 8'h22, 1'b0);
        bus.req = 4'b0110;
        wait_gnt(got);
        check("bp_gnt", 32'(bus.gnt), 32'b0010);
        bus.req[1] = 1'b0;
        e = model(1, 8'hA5, 8'h3C, 1'b1);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1;
                break;
            end
        end
        check("bp_valid_seen", 32'(got), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(bus.resp_valid), 32'd1);
            check("bp_no_gnt",     32'(bus.gnt),        32'd0);
            check("bp_sum_stable", 32'(bus.resp_sum),   32'(e.sum));
            check("bp_id_stable",  32'(bus.resp_id),    32'(e.id));
        end
        step();
        bus.resp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (bus.gnt != '0) break;
        end
        check("bp_next_gnt", 32'(bus.gnt), 32'b0100);
        check("bp_next_gnt_delay", 32'(n), 32'd3);
        bus.req = '0;
        drain();

        // SETTLE=4 instance: latency and operand stability through EXEC.
        step();
        bus4.req_a[1*N +: N] = 8'h5A;
        bus4.req_b[1*N +: N] = 8'hC3;
        bus4.req_cin[1]      = 1'b1;
        bus4.req[1]          = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus4.gnt != '0) begin
                got = 1;
                break;
            end
        end
        check("s4_gnt", 32'(bus4.gnt), 32'b0010);
        bus4.req[1] = 1'b0;
        e = model(1, 8'h5A, 8'hC3, 1'b1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (bus4.resp_valid) break;
            check("s4_add_a_stable", 32'(add_a4), 32'h5A);
            check("s4_no_regrant",   32'(bus4.gnt), 32'd0);
        end
        check("s4_latency",   32'(n),              32'd4);
        check("s4_resp_sum",  32'(bus4.resp_sum),  32'(e.sum));
        check("s4_resp_cout", 32'(bus4.resp_cout), 32'(e.cout));
        check("s4_resp_id",   32'(bus4.resp_id),   32'(e.id));
        drain();

        // Reset mid-EXEC: pointer is 3, requester 1 wins and moves it to 2.
        step();
        set_op(1, 8'h44, 8'h55, 1'b1);
        bus.req = 4'b0010;
        wait_gnt(got);
        check("mid_gnt", 32'(bus.gnt), 32'b0010);
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        sb_q.delete();
        check("mid_rst_gnt",        32'(bus.gnt),        32'd0);
        check("mid_rst_add_a",      32'(add_a),          32'd0);
        check("mid_rst_add_b",      32'(add_b),          32'd0);
        check("mid_rst_add_cin",    32'(add_cin),        32'd0);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_resp_sum",   32'(bus.resp_sum),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.gnt != '0) n++;
        end
        check("mid_no_response", 32'(n), 32'd0);
        step();
        set_op(0, 8'h01, 8'h02, 1'b0);
        set_op(2, 8'h03, 8'h04, 1'b0);
        bus.req = 4'b0101;
        wait_gnt(got);
        check("mid_ptr_reset_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        drain();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencing controller that time-shares one external N-bit ripple-carry adder among R requesters. Arbitration is round-robin. The controller latches the winner's operands, holds them on the adder inputs for a programmable settle time, then captures sum and carry into a result register. The result is returned with a valid/ready handshake tagged with the requester ID. It sits between the requesting datapath units and the single instance of the team's ripple adder, so no requester drives the adder directly.

## Interface
- N, 8, operand/sum width; matches the adder width
- R, 4, number of requesters, 2..8
- SETTLE, 1, cycles operands are held on the adder before capture, 1..15
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  R  per-requester request level; held with operands until gnt seen
- req_a  in  R*N  operand A, requester i at bits [i*N +: N]
- req_b  in  R*N  operand B, same packing
- req_cin  in  R  carry-in per requester
- gnt  out  R  one-hot, one-cycle pulse: operands of that requester were captured
- add_a  out  N  registered operand A to adder
- add_b  out  N  registered operand B to adder
- add_cin  out  1  registered carry-in to adder
- add_sum  in  N  adder sum (combinational from add_a/add_b/add_cin)
- add_cout  in  1  adder carry-out
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  clog2(R)  index of requester the result belongs to
- resp_sum  out  N  captured sum
- resp_cout  out  1  captured carry-out

## Operation
- States: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE, req != 0 at edge:
  - winner = first set bit of req, searched from pointer ptr upward with wrap.
  - load add_a/add_b/add_cin from the winner.
  - gnt[winner]=1 for the next cycle.
  - store id; cnt = SETTLE-1; → EXEC.
- IDLE, req == 0: stay; add_* hold last values.
- EXEC: cnt==0 at edge → resp_sum/resp_cout/resp_id captured, resp_valid=1, → RESP; otherwise cnt decrements.
- RESP: resp_valid && resp_ready at edge → resp_valid=0, → IDLE. Otherwise hold; payload is stable while valid.
- ptr updates on grant to (winner+1) mod R. Reset value of ptr is 0.
- Requests arriving in EXEC/RESP wait; they are not arbitrated until IDLE.
- Arithmetic: no width change; resp_sum = (a+b+cin) mod 2^N and resp_cout = bit N, exactly as delivered by the adder.

## Timing
- Reset values:
  - gnt=0, add_a=0, add_b=0, add_cin=0
  - resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0
  - ptr=0, cnt=0, state IDLE
- Request sampled at edge E: gnt high in cycle E..E+1; resp_valid high after edge E+SETTLE.
- With resp_ready held high, one operation takes SETTLE+2 cycles. Back-to-back service with SETTLE=1 is one grant per 3 cycles.
- resp_ready low: controller stalls in RESP indefinitely; no new grants.
- A requester dropping req before gnt forfeits the request; no response is produced.
- rst_n asserted mid-EXEC/RESP: operation discarded, no response, gnt not reissued; requester must re-request after reset.

## Configuration
- ADDER_SHARE_OVF_EN defined: adds output resp_ovf (1 bit, reset 0).
  - Captured with resp_sum as signed overflow: add_a[N-1]==add_b[N-1] && add_sum[N-1]!=add_a[N-1].
  - Held while resp_valid.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package `adder_share_pkg`: state encoding constants (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), default N/R/SETTLE, ID-width function clog2.
- One sub-module: `rr_arbiter` (req, ptr → one-hot winner and index), combinational, parameterized by R.
- The adder itself stays outside; a top-level wrapper connects add_* to the adder instance.

## Test plan
- Reset and single request:
  - N=8, req=4'b0001, a=8'h0F, b=8'h01, cin=0 → gnt=0001 one cycle.
  - resp_valid after 2 edges, resp_sum=8'h10, resp_cout=0, resp_id=0.
- Carry-out: a=8'hFF, b=8'h01, cin=1 → resp_sum=8'h01, resp_cout=1. With ADDER_SHARE_OVF_EN: a=8'h7F, b=8'h01 → resp_ovf=1.
- Round-robin with all four requesting continuously (resp_ready=1) → grant order 0,1,2,3,0; each gnt spaced 3 cycles.
- Backpressure: resp_ready=0 for 10 cycles → resp_valid stays 1, payload unchanged, gnt stays 0; ready=1 → IDLE, next grant follows.
- SETTLE=4: req at edge E → resp_valid after edge E+4, and add_a stable throughout EXEC.
- Reset mid-EXEC: rst_n low one cycle → all outputs return to reset values, no resp_valid; ptr=0, so the next arbitration starts from requester 0.
